// File: rtl/ecc_result_buffer_if.sv
// Result handshake bus between the ECC result buffer and its sink.
// The buffer drives the head-of-queue result and valid; the sink drives ready.
interface ecc_result_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] res_data;
    logic [1:0]            res_err;
    logic                  res_valid;
    logic                  res_ready;

    modport master (
        output res_data,
        output res_err,
        output res_valid,
        input  res_ready
    );

    modport slave (
        input  res_data,
        input  res_err,
        input  res_valid,
        output res_ready
    );
endinterface

// File: rtl/ecc_result_buffer.sv
// ECC result buffer: queues each completed ECC core operation in a
// first-word-fall-through FIFO, hands results to a sink over valid/ready and
// keeps saturating error statistics. The core never stalls, so a result that
// arrives while the queue is full and nothing leaves is dropped and flagged.
module ecc_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   i_data_out,
    input  logic                    i_operation_done,
    input  logic [1:0]              i_num_of_errors,
    ecc_result_buffer_if.master     o_res,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_full,
    output logic                    o_overflow,
    input  logic                    i_clr_stats,
    output logic [CNT_WIDTH-1:0]    o_cnt_ops,
    output logic [CNT_WIDTH-1:0]    o_cnt_single,
    output logic [CNT_WIDTH-1:0]    o_cnt_double,
    output logic [CNT_WIDTH-1:0]    o_cnt_dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DATA_WIDTH + 2;

    localparam logic [LW-1:0]        FULL_LEVEL = LW'(DEPTH);
    localparam logic [LW-1:0]        LEVEL_ONE  = LW'(1);
    localparam logic [AW-1:0]        PTR_ONE    = AW'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    // Each entry holds {num_of_errors, data_out}; storage is not reset.
    logic [EW-1:0]  r_mem [DEPTH];
    logic [AW-1:0]  r_wrPtr;
    logic [AW-1:0]  r_rdPtr;
    logic [LW-1:0]  r_level;

    logic [CNT_WIDTH-1:0] r_cntOps;
    logic [CNT_WIDTH-1:0] r_cntSingle;
    logic [CNT_WIDTH-1:0] r_cntDouble;
    logic [CNT_WIDTH-1:0] r_cntDropped;
    logic                 r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_isSingle;
    logic          w_isDouble;
    logic [LW-1:0] w_levelNext;
    logic [EW-1:0] w_head;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    // Handshake decode: a pop frees a slot in the same cycle, so a full queue
    // can still accept a result when the sink takes the head.
    always_comb begin
        w_empty     = (r_level == '0);
        w_full      = (r_level == FULL_LEVEL);
        w_pop       = !w_empty && o_res.res_ready;
        w_push      = i_operation_done && (!w_full || w_pop);
        w_drop      = i_operation_done && !w_push;
        w_isSingle  = (i_num_of_errors == 2'b01);
        w_isDouble  = (i_num_of_errors == 2'b10);
        w_levelNext = r_level;
        if (w_push && !w_pop) begin
            w_levelNext = r_level + LEVEL_ONE;
        end else if (w_pop && !w_push) begin
            w_levelNext = r_level - LEVEL_ONE;
        end
    end

    // Read/write pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            r_level <= w_levelNext;
        end
    end

    // Result storage write; contents are only meaningful below the level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {i_num_of_errors, i_data_out};
        end
    end

    // Statistics: a clear wins over a same-cycle event, which is then not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntOps     <= '0;
            r_cntSingle  <= '0;
            r_cntDouble  <= '0;
            r_cntDropped <= '0;
            r_overflow   <= 1'b0;
        end else if (i_clr_stats) begin
            r_cntOps     <= '0;
            r_cntSingle  <= '0;
            r_cntDouble  <= '0;
            r_cntDropped <= '0;
            r_overflow   <= 1'b0;
        end else if (i_operation_done) begin
            r_cntOps <= satInc(r_cntOps);
            if (w_isSingle) begin
                r_cntSingle <= satInc(r_cntSingle);
            end
            if (w_isDouble) begin
                r_cntDouble <= satInc(r_cntDouble);
            end
            if (w_drop) begin
                r_cntDropped <= satInc(r_cntDropped);
                r_overflow   <= 1'b1;
            end
        end
    end

    // Head of queue presented first-word-fall-through, forced to zero when empty
    // so stale storage never leaks onto the bus.
    always_comb begin
        w_head          = r_mem[r_rdPtr];
        o_res.res_valid = !w_empty;
        o_res.res_data  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
        o_res.res_err   = w_empty ? 2'b00 : w_head[EW-1:DATA_WIDTH];
        o_level         = r_level;
        o_full          = w_full;
        o_overflow      = r_overflow;
        o_cnt_ops       = r_cntOps;
        o_cnt_single    = r_cntSingle;
        o_cnt_double    = r_cntDouble;
        o_cnt_dropped   = r_cntDropped;
    end

endmodule

// File: tb/tb_ecc_result_buffer.sv
// Testbench for ecc_result_buffer: two instances (16-bit and 4-bit counters)
// share one stimulus stream; a queue-based model predicts every output.
module tb_ecc_result_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] dataOut = '0;
   logic          opDone = 1'b0;
   logic [1:0]    numErr = 2'b00;
   logic          ready = 1'b0;
   logic          clrStats = 1'b0;

   logic [3:0]  levelA, levelB;
   logic        fullA, fullB, ovfA, ovfB;
   logic [15:0] opsA, singleA, doubleA, droppedA;
   logic [3:0]  opsB, singleB, doubleB, droppedB;

   ecc_result_buffer_if #(.DATA_WIDTH(DW)) busA ();
   ecc_result_buffer_if #(.DATA_WIDTH(DW)) busB ();

   assign busA.res_ready = ready;
   assign busB.res_ready = ready;

   ecc_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(16)) dutA (
      .clk(clk), .rst_n(rst_n),
      .i_data_out(dataOut), .i_operation_done(opDone), .i_num_of_errors(numErr),
      .o_res(busA),
      .o_level(levelA), .o_full(fullA), .o_overflow(ovfA), .i_clr_stats(clrStats),
      .o_cnt_ops(opsA), .o_cnt_single(singleA), .o_cnt_double(doubleA), .o_cnt_dropped(droppedA)
   );

   ecc_result_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(4)) dutB (
      .clk(clk), .rst_n(rst_n),
      .i_data_out(dataOut), .i_operation_done(opDone), .i_num_of_errors(numErr),
      .o_res(busB),
      .o_level(levelB), .o_full(fullB), .o_overflow(ovfB), .i_clr_stats(clrStats),
      .o_cnt_ops(opsB), .o_cnt_single(singleB), .o_cnt_double(doubleB), .o_cnt_dropped(droppedB)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   // Reference model: plain queue of {err,data} plus event counts since last clear
   logic [DW+1:0] mq[$];
   int nOps, nSingle, nDouble, nDropped;
   bit mOvf;
   int checks = 0;
   int errors = 0;

   function automatic int sat(input int n, input int maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mq.delete();
      nOps = 0; nSingle = 0; nDouble = 0; nDropped = 0;
      mOvf = 1'b0;
   endtask

   task automatic modelStep(input logic [DW-1:0] d, input logic dn, input logic [1:0] e,
                            input logic rdy, input logic c);
      bit pop, push;
      pop  = (mq.size() > 0) && rdy;
      push = dn && ((mq.size() < DEPTH) || pop);
      if (c) begin
         nOps = 0; nSingle = 0; nDouble = 0; nDropped = 0;
         mOvf = 1'b0;
      end else if (dn) begin
         nOps++;
         if (e == 2'b01) nSingle++;
         if (e == 2'b10) nDouble++;
         if (!push) begin
            nDropped++;
            mOvf = 1'b1;
         end
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({e, d});
   endtask

   task automatic checkAll();
      logic [DW+1:0] head;
      logic          expValid;
      head     = (mq.size() > 0) ? mq[0] : '0;
      expValid = (mq.size() > 0);
      checkOutput("validA",   64'(busA.res_valid), 64'(expValid));
      checkOutput("dataA",    64'(busA.res_data),  64'(head[DW-1:0]));
      checkOutput("errA",     64'(busA.res_err),   64'(head[DW+1:DW]));
      checkOutput("levelA",   64'(levelA),         64'(mq.size()));
      checkOutput("fullA",    64'(fullA),          64'(mq.size() == DEPTH));
      checkOutput("ovfA",     64'(ovfA),           64'(mOvf));
      checkOutput("opsA",     64'(opsA),           64'(sat(nOps, 65535)));
      checkOutput("singleA",  64'(singleA),        64'(sat(nSingle, 65535)));
      checkOutput("doubleA",  64'(doubleA),        64'(sat(nDouble, 65535)));
      checkOutput("droppedA", 64'(droppedA),       64'(sat(nDropped, 65535)));
      checkOutput("validB",   64'(busB.res_valid), 64'(expValid));
      checkOutput("dataB",    64'(busB.res_data),  64'(head[DW-1:0]));
      checkOutput("levelB",   64'(levelB),         64'(mq.size()));
      checkOutput("ovfB",     64'(ovfB),           64'(mOvf));
      checkOutput("opsB",     64'(opsB),           64'(sat(nOps, 15)));
      checkOutput("singleB",  64'(singleB),        64'(sat(nSingle, 15)));
      checkOutput("doubleB",  64'(doubleB),        64'(sat(nDouble, 15)));
      checkOutput("droppedB", 64'(droppedB),       64'(sat(nDropped, 15)));
   endtask

   // One clock of stimulus: drive on the falling edge, check 1 unit after the rising edge
   task automatic applyStimulus(input logic [DW-1:0] d, input logic dn, input logic [1:0] e,
                                input logic rdy, input logic c);
      @(negedge clk);
      dataOut  = d;
      opDone   = dn;
      numErr   = e;
      ready    = rdy;
      clrStats = c;
      modelStep(d, dn, e, rdy, c);
      @(posedge clk);
      #1;
      checkAll();
   endtask

   initial begin
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      checkAll();
      @(negedge clk);
      rst_n = 1'b1;

      // Single result with one corrected error, then accept it
      applyStimulus(32'hDEADBEEF, 1'b1, 2'b01, 1'b0, 1'b0);
      checkOutput("t2_valid",  64'(busA.res_valid), 64'(1));
      checkOutput("t2_data",   64'(busA.res_data),  64'h0000_0000_DEAD_BEEF);
      checkOutput("t2_err",    64'(busA.res_err),   64'(2'b01));
      checkOutput("t2_single", 64'(singleA),        64'(1));
      applyStimulus('0, 1'b0, 2'b00, 1'b1, 1'b0);
      checkOutput("t2_empty",  64'(busA.res_valid), 64'(0));

      // Nine back-to-back results into a depth-8 queue: the ninth is dropped
      applyStimulus('0, 1'b0, 2'b00, 1'b0, 1'b1);
      for (int i = 1; i <= 9; i++) applyStimulus(DW'(i), 1'b1, 2'b00, 1'b0, 1'b0);
      checkOutput("t3_full",    64'(fullA),    64'(1));
      checkOutput("t3_level",   64'(levelA),   64'(8));
      checkOutput("t3_ovf",     64'(ovfA),     64'(1));
      checkOutput("t3_dropped", 64'(droppedA), 64'(1));
      checkOutput("t3_ops",     64'(opsA),     64'(9));
      for (int i = 1; i <= 8; i++) begin
         checkOutput("t3_drain", 64'(busA.res_data), 64'(i));
         applyStimulus('0, 1'b0, 2'b00, 1'b1, 1'b0);
      end
      checkOutput("t3_done", 64'(busA.res_valid), 64'(0));

      // Full queue with a same-cycle push and pop keeps level and drops nothing
      for (int i = 0; i < 8; i++) applyStimulus(DW'(32'h10 + i), 1'b1, 2'b00, 1'b0, 1'b0);
      applyStimulus('0, 1'b0, 2'b00, 1'b0, 1'b1);
      applyStimulus(32'hAA, 1'b1, 2'b00, 1'b1, 1'b0);
      checkOutput("t4_level", 64'(levelA), 64'(8));
      checkOutput("t4_ovf",   64'(ovfA),   64'(0));
      for (int i = 0; i < 8; i++) begin
         checkOutput("t4_drain", 64'(busA.res_data), (i < 7) ? 64'(32'h11 + i) : 64'hAA);
         applyStimulus('0, 1'b0, 2'b00, 1'b1, 1'b0);
      end

      // Error-class statistics, then a clear that beats a coincident strobe
      applyStimulus('0, 1'b0, 2'b00, 1'b0, 1'b1);
      applyStimulus(32'h50, 1'b1, 2'b00, 1'b0, 1'b0);
      applyStimulus(32'h51, 1'b1, 2'b01, 1'b0, 1'b0);
      applyStimulus(32'h52, 1'b1, 2'b10, 1'b0, 1'b0);
      applyStimulus(32'h53, 1'b1, 2'b11, 1'b0, 1'b0);
      applyStimulus(32'h54, 1'b1, 2'b10, 1'b0, 1'b0);
      checkOutput("t5_ops",    64'(opsA),    64'(5));
      checkOutput("t5_single", 64'(singleA), 64'(1));
      checkOutput("t5_double", 64'(doubleA), 64'(2));
      applyStimulus(32'h55, 1'b1, 2'b01, 1'b0, 1'b1);
      checkOutput("t5_clrOps",   64'(opsA),   64'(0));
      checkOutput("t5_clrLevel", 64'(levelA), 64'(6));
      for (int i = 0; i < 6; i++) applyStimulus('0, 1'b0, 2'b00, 1'b1, 1'b0);

      // Counter saturation on the 4-bit instance
      applyStimulus('0, 1'b0, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) applyStimulus($urandom, 1'b1, 2'b01, 1'b1, 1'b0);
      checkOutput("t6_opsB",    64'(opsB),    64'(15));
      checkOutput("t6_singleB", 64'(singleB), 64'(15));
      checkOutput("t6_opsA",    64'(opsA),    64'(20));

      // Randomized traffic with an asynchronous reset in the middle
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            @(negedge clk);
            opDone = 1'b1;
            rst_n  = 1'b0;
            #2;
            modelReset();
            checkOutput("t1_valid", 64'(busA.res_valid), 64'(0));
            checkOutput("t1_level", 64'(levelA),         64'(0));
            checkOutput("t1_ovf",   64'(ovfA),           64'(0));
            checkOutput("t1_ops",   64'(opsA),           64'(0));
            checkOutput("t1_drop",  64'(droppedA),       64'(0));
            @(posedge clk);
            #1;
            checkAll();
            @(negedge clk);
            opDone = 1'b0;
            rst_n  = 1'b1;
         end
         applyStimulus($urandom, ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                       ($urandom_range(0, 9) < 4), ($urandom_range(0, 49) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
